// File: rtl/alu_stream_pkg.sv
// rtl/alu_stream_pkg.sv - opcodes, FSM states and flag bit indices shared by alu_stream
package alu_stream_pkg;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_XOR  = 5'd2;
    localparam logic [4:0] OP_NOT  = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_NAND = 5'd5;
    localparam logic [4:0] OP_ADD  = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLT  = 5'd11;
    localparam logic [4:0] OP_CLZ  = 5'd12;
    localparam logic [4:0] OP_CTZ  = 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;
    localparam logic [4:0] OP_REM  = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rsp_flags is packed {V, C, N, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_iter_div.sv
// rtl/alu_iter_div.sv - iterative restoring divider, present only when ALU_STREAM_DIV_EN is defined
`ifdef ALU_STREAM_DIV_EN
module alu_iter_div
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             rem_sel,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] result_r;
    logic             neg_q;
    logic             neg_r;
    logic             rem_sel_r;
    logic             div0_r;

    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Operand magnitudes for the signed case; unsigned operands pass through
    always_comb begin
        a_mag_in = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag_in = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // One restoring step: shift in the next dividend bit and try to subtract the divisor
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_mag});
        diff    = shifted[WIDTH-1:0] - b_mag;
    end

    // WIDTH quotient-bit iterations followed by one sign-fixup cycle that loads result_r
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            b_mag     <= '0;
            result_r  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_sel_r <= 1'b0;
            div0_r    <= 1'b0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= a_mag_in;
            b_mag     <= b_mag_in;
            div0_r    <= (b == '0);
            // a zero divisor must yield an all-ones quotient, so it is never negated
            neg_q     <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            neg_r     <= is_signed && a[WIDTH-1];
            rem_sel_r <= rem_sel;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy     <= 1'b0;
                result_r <= rem_sel_r ? (neg_r ? -rem_r : rem_r)
                                      : (neg_q ? -quo_r : quo_r);
            end else begin
                rem_r <= ge ? diff : shifted[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], ge};
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // done marks the fixup cycle; result is valid from the next cycle until the next start
    assign done   = busy && (cnt == LAST);
    assign result = result_r;
    assign div0   = div0_r;

endmodule
`endif

// File: rtl/alu_stream.sv
// rtl/alu_stream.sv - handshaked integer ALU; ALU_STREAM_DIV_EN enables the iterative DIV/REM unit
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_error
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             carry;
    logic             slt;
    logic [WIDTH-1:0] clz_cnt;
    logic [WIDTH-1:0] ctz_cnt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;
    logic             alu_error;
    logic             slot_free;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign shamt     = req_b[SW-1:0];
    assign slot_free = !rsp_valid || rsp_ready;

    // Adder, subtractor and set-less-than shared by the opcode decode below
    always_comb begin
        {carry, sum} = {1'b0, req_a} + {1'b0, req_b};
        dif          = req_a - req_b;
        slt          = req_signed ? ($signed(req_a) < $signed(req_b)) : (req_a < req_b);
    end

    // Leading-zero count: the highest set bit wins, zero input gives WIDTH
    always_comb begin
        clz_cnt = WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (req_a[i]) clz_cnt = WIDTH'(WIDTH - 1 - i);
        end
    end

    // Trailing-zero count: the lowest set bit wins, zero input gives WIDTH
    always_comb begin
        ctz_cnt = WIDTH'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_a[i]) ctz_cnt = WIDTH'(i);
        end
    end

    // Single-cycle opcode decode; anything not listed (including DIV/REM here) is illegal
    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_error  = 1'b0;
        case (req_op)
            OP_AND:  alu_result = req_a & req_b;
            OP_OR:   alu_result = req_a | req_b;
            OP_XOR:  alu_result = req_a ^ req_b;
            OP_NOT:  alu_result = ~req_a;
            OP_NOR:  alu_result = ~(req_a | req_b);
            OP_NAND: alu_result = ~(req_a & req_b);
            OP_ADD: begin
                alu_result = sum;
                alu_c      = carry;
                alu_v      = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (sum[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = dif;
                alu_c      = (req_a < req_b);
                alu_v      = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (dif[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SLL:  alu_result = req_a << shamt;
            OP_SRL:  alu_result = req_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(req_a) >>> shamt);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt};
            OP_CLZ:  alu_result = clz_cnt;
            OP_CTZ:  alu_result = ctz_cnt;
            default: alu_error  = 1'b1;
        endcase
    end

`ifdef ALU_STREAM_DIV_EN
    state_t           state;
    logic             is_div_op;
    logic             div_start;
    logic             div_done;
    logic             div0;
    logic [WIDTH-1:0] div_result;

    assign is_div_op = (req_op == OP_DIV) || (req_op == OP_REM);
    assign req_ready = (state == ST_IDLE) && slot_free;
    assign div_start = req_valid && req_ready && is_div_op;

    alu_iter_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .a         (req_a),
        .b         (req_b),
        .is_signed (req_signed),
        .rem_sel   (req_op == OP_REM),
        .done      (div_done),
        .result    (div_result),
        .div0      (div0)
    );

    // Control FSM and response register: single-cycle results load on accept, divides via DIV/DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (is_div_op) begin
                            state <= ST_DIV;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_result <= alu_result;
                            rsp_flags  <= make_flags(alu_result, alu_c, alu_v);
                            rsp_error  <= alu_error;
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (slot_free) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= div_result;
                        rsp_flags  <= make_flags(div_result, 1'b0, 1'b0);
                        rsp_error  <= div0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign req_ready = slot_free;

    // Response register: every accepted request completes in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            if (req_valid && req_ready) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_flags  <= make_flags(alu_result, alu_c, alu_v);
                rsp_error  <= alu_error;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_stream.sv
// tb/tb_alu_stream.sv - table-driven self-checking bench for alu_stream (WIDTH=32)
module tb_alu_stream;
    import alu_stream_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_error;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    alu_stream #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_error  (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input logic [31:0] res, input logic [3:0] flags,
                                input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sgn = sgn;
        v.res = res; v.flags = flags; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        req_op     = v.op;
        req_a      = v.a;
        req_b      = v.b;
        req_signed = v.sgn;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_req_ready", idx), {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check($sformatf("vec%0d_valid", idx), {31'b0, rsp_valid}, 32'd1);
        check($sformatf("vec%0d_result", idx), rsp_result, v.res);
        check($sformatf("vec%0d_flags", idx), {28'b0, rsp_flags}, {28'b0, v.flags});
        check($sformatf("vec%0d_error", idx), {31'b0, rsp_error}, {31'b0, v.err});
    endtask

`ifdef ALU_STREAM_DIV_EN
    task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic sgn, input logic [31:0] exp_res,
                           input logic exp_err);
        int cyc;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_signed = sgn;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({name, "_busy"}, {31'b0, req_ready}, 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, 32'd34);
        check({name, "_result"}, rsp_result, exp_res);
        check({name, "_error"}, {31'b0, rsp_error}, {31'b0, exp_err});
    endtask
`endif

    initial begin
        logic [31:0] held;
        logic        seen;
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = 1'b0;
        rsp_ready  = 1'b0;

        vecs.push_back(mk(OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h00F0_000F, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_OR,   32'h1200_0000, 32'h0000_0034, 1'b0, 32'h1200_0034, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_XOR,  32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(OP_NOT,  32'h0000_0000, 32'h0000_1234, 1'b0, 32'hFFFF_FFFF, 4'b0010, 1'b0));
        vecs.push_back(mk(OP_NOR,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1010, 1'b0));
        vecs.push_back(mk(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_ADD,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1101, 1'b0));
        vecs.push_back(mk(OP_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0110, 1'b0));
        vecs.push_back(mk(OP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1000, 1'b0));
        vecs.push_back(mk(OP_SUB,  32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 4'b0110, 1'b0));
        vecs.push_back(mk(OP_SLL,  32'h0000_0001, 32'h0000_001F, 1'b0, 32'h8000_0000, 4'b0010, 1'b0));
        vecs.push_back(mk(OP_SRL,  32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_SRA,  32'h8000_0000, 32'h0000_0024, 1'b0, 32'hF800_0000, 4'b0010, 1'b0));
        vecs.push_back(mk(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(OP_CLZ,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0020, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_CLZ,  32'h0001_0000, 32'h0000_0000, 1'b0, 32'h0000_000F, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_CTZ,  32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0008, 4'b0000, 1'b0));
        vecs.push_back(mk(OP_CTZ,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0020, 4'b0000, 1'b0));
        vecs.push_back(mk(5'd20,   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0000_0000, 4'b0001, 1'b1));
        vecs.push_back(mk(5'd31,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b0001, 1'b1));
`ifndef ALU_STREAM_DIV_EN
        vecs.push_back(mk(OP_DIV,  32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_0000, 4'b0001, 1'b1));
        vecs.push_back(mk(OP_REM,  32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_0000, 4'b0001, 1'b1));
`endif

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid",  {31'b0, rsp_valid}, 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_flags",  {28'b0, rsp_flags}, 32'd0);
        check("reset_error",  {31'b0, rsp_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

        // 8 back-to-back XORs, one response per cycle
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_op     = OP_XOR;
        req_signed = 1'b0;
        req_b      = 32'hA5A5_5A5A;
        for (int i = 0; i < 8; i++) begin
            req_a = 32'(i) * 32'h0001_0003;
            @(negedge clk);
            check($sformatf("stream%0d_req_ready", i), {31'b0, req_ready}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("stream%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("stream%0d_result", i), rsp_result, (32'(i) * 32'h0001_0003) ^ 32'hA5A5_5A5A);
        end

        // backpressure: response held, req_ready low
        held      = (32'd7 * 32'h0001_0003) ^ 32'hA5A5_5A5A;
        rsp_ready = 1'b0;
        req_a     = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_req_ready", k), {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d_result", k), rsp_result, held);
        end

        // consume and accept on the same edge, no bubble
        rsp_ready = 1'b1;
        @(negedge clk);
        check("resume_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("resume_valid",  {31'b0, rsp_valid}, 32'd1);
        check("resume_result", rsp_result, 32'h1234_5678 ^ 32'hA5A5_5A5A);
        @(posedge clk); #1;
        check("drain_valid", {31'b0, rsp_valid}, 32'd0);

        // reset while a response is pending
        rsp_ready = 1'b0;
        req_op    = OP_ADD;
        req_a     = 32'd2;
        req_b     = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pend_result", rsp_result, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("pend_rst_valid",  {31'b0, rsp_valid}, 32'd0);
        check("pend_rst_result", rsp_result, 32'd0);
        apply_vec(100, mk(OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0000, 4'b0000, 1'b0));

`ifdef ALU_STREAM_DIV_EN
        run_div("div_neg",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        run_div("rem_neg",  OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_div("div_u",    OP_DIV, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0);
        run_div("div_zero", OP_DIV, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_div("rem_zero", OP_REM, 32'd5, 32'd0, 1'b0, 32'd5, 1'b1);
        run_div("div_ovf",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0);

        // reset 10 cycles into a divide discards it
        req_op     = OP_DIV;
        req_a      = 32'd1000;
        req_b      = 32'd3;
        req_signed = 1'b0;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("divrst_valid", {31'b0, rsp_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("divrst_no_result", {31'b0, seen}, 32'd0);
        apply_vec(101, mk(OP_AND, 32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 32'h0000_00FF, 4'b0000, 1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_stream.md
# alu_stream

`alu_stream` is the parametrised, handshaked integer ALU that succeeds the first-generation start/busy ALU in the NOSE datapath. It accepts one operation per cycle over a valid/ready request channel and returns results with status flags over a valid/ready response channel. Single-cycle operations run at full throughput. Divide and remainder use an optional iterative sub-unit. All widths derive from `WIDTH`; there are no hard-coded 32-bit constants.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 8 and a power of two.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when this and `req_valid` are both high at a rising edge.
- `req_op` in 5: opcode.
- `req_a`, `req_b` in WIDTH: operands.
- `req_signed` in 1: signed interpretation for SLT, DIV and REM.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_result` out WIDTH: result.
- `rsp_flags` out 4: {V, C, N, Z}.
- `rsp_error` out 1: illegal opcode, or divide by zero.

## Operation
Opcodes:
- 0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 NOR, 5 NAND.
- 6 ADD, 7 SUB.
- 8 SLL, 9 SRL, 10 SRA: shift amount is `b[$clog2(WIDTH)-1:0]`.
- 11 SLT: result 1 or 0.
- 12 CLZ(a), 13 CTZ(a): count of zero a is WIDTH; the count is zero-extended.
- 14 DIV, 15 REM.
- 16–31 illegal: result 0, error 1.

Flags:
- Z = (result == 0); N = result[WIDTH-1].
- C: carry-out for ADD; borrow for SUB, i.e. 1 when a < b unsigned.
- V: signed overflow for ADD and SUB.
- C = V = 0 for all other ops.

Division rules (RISC-V semantics):
- Divide by zero: quotient all-ones, remainder = a, error 1.
- Signed MIN / −1: quotient MIN, remainder 0, error 0.
- Signed operation divides magnitudes, then negates results: quotient is negative when the operand signs differ; remainder takes the sign of a.

FSM states:
- IDLE: single-cycle ops are computed combinationally and written into the response register on the accept edge. A DIV or REM accept latches the operands and moves to DIV.
- DIV: restoring divide, one quotient bit per cycle, WIDTH cycles, then one sign-fixup cycle, then DONE.
- DONE: waits until the response register is free, loads it, returns to IDLE.

## Timing
- Reset values: `rsp_valid` 0, `rsp_result` 0, `rsp_flags` 0, `rsp_error` 0, state IDLE. `req_ready` is 1 in the cycle after reset deasserts.
- `req_ready = (state == IDLE) && (!rsp_valid || rsp_ready)`, combinational. `req_ready` never depends on `req_valid`.
- Single-cycle op accepted at edge N: `rsp_valid` is high from N+1. Back-to-back accepts with `rsp_ready` held high give one result per cycle.
- DIV/REM accepted at edge N: `rsp_valid` at N+WIDTH+2 if the response slot is free; otherwise it stalls in DONE. `req_ready` is low from N+1 until the result is loaded.
- Response stability: `rsp_result`, `rsp_flags` and `rsp_error` are held stable while `rsp_valid && !rsp_ready`.
- Simultaneous consume and accept: the response is consumed and the new result loaded on the same edge, with no bubble.
- `rst` mid-divide aborts the divide. The outputs take their reset values on that edge, and the partial result is discarded.

## Configuration
- `ALU_STREAM_DIV_EN` defined: the divider sub-unit is instantiated, and DIV/REM behave as above.
- `ALU_STREAM_DIV_EN` undefined:
  - Opcodes 14 and 15 are treated as illegal: single-cycle response, result 0, error 1.
  - The DIV and DONE states and all divider logic are removed.

## Structure
- Package `alu_stream_pkg` holds:
  - the opcode localparams `OP_AND` … `OP_REM`;
  - the FSM state enum;
  - the flag bit-index constants `FLAG_Z`, `FLAG_N`, `FLAG_C`, `FLAG_V`.
- Sub-module `alu_iter_div`:
  - parameter WIDTH;
  - ports: start, a, b, signed, rem_sel, done, result, div0;
  - contains the sign handling and the WIDTH-cycle loop;
  - compiled only under `ALU_STREAM_DIV_EN`.
- Everything else stays in `alu_stream`.

## Test plan
1. **Add/sub flags (WIDTH=32).**
   - ADD 0x7FFFFFFF + 1 → 0x80000000, N=1, V=1, C=0.
   - SUB 0 − 1 → 0xFFFFFFFF, C=1, N=1.
2. **Streaming and backpressure.**
   - 8 back-to-back XORs with `rsp_ready`=1 → 8 responses on consecutive cycles.
   - Drop `rsp_ready` for 3 cycles → `req_ready` is low and the held response does not change.
3. **Shift and count.**
   - SRA 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
   - CLZ 0 → 32; CTZ 0x00000100 → 8.
4. **Signed division.**
   - DIV −7 / 2 → 0xFFFFFFFD.
   - REM −7 / 2 → 0xFFFFFFFF.
   - `rsp_valid` asserts exactly 34 cycles after accept.
5. **Division corner cases.**
   - DIV 5 / 0 → 0xFFFFFFFF, error 1.
   - REM 5 / 0 → 5, error 1.
   - Signed DIV 0x80000000 / −1 → 0x80000000, error 0.
6. **Reset and illegal opcode.**
   - Assert `rst` 10 cycles into a divide → `rsp_valid` is 0 next cycle, and a following AND returns correctly.
   - Opcode 20 → result 0, error 1.
